// File: rtl/bp_pkg.sv
// Shared constants, FSM encoding and requester IDs for the perceptron weight RAM arbiter.
// No logic; no latency; no flow control.
package bp_pkg;

    localparam int BP_STORAGE_B  = 88;
    localparam int BP_ADDR_WIDTH = 7;
    localparam int BP_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE_WE,
        ST_WRITE_HOLD,
        ST_CLEAR_WE,
        ST_CLEAR_HOLD
    } state_t;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_T = 1'b1
    } req_id_t;

endpackage

// File: rtl/bp_rr_picker.sv
// 2-way requester picker: fixed trainer>predictor, or round-robin when BP_ARB_RR_EN is defined.
// Pick is combinational; last-granted updates on the accepting edge; requests simply wait.
module bp_rr_picker
    import bp_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    p_req,
    input  logic    t_req,
    input  logic    fire,
    output req_id_t pick,
    output req_id_t last
);

`ifdef BP_ARB_RR_EN
    // On a tie the requester not granted last time wins.
    always_comb begin
        pick = (t_req && (!p_req || last == REQ_P)) ? REQ_T : REQ_P;
    end
`else
    always_comb begin
        pick = (t_req || !p_req) ? REQ_T : REQ_P;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_T;
        end else if (fire) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/bp_mem_arbiter.sv
// Owns the latch weight RAM: arbitrates predictor/trainer, sequences WE+hold writes, runs full clear.
// Read gnt->rvalid 1 cycle, write 3 cycles incl. IDLE, clear 2*STORAGE_B; losers hold req until gnt.
module bp_mem_arbiter
    import bp_pkg::*;
#(
    parameter int                    STORAGE_B  = BP_STORAGE_B,
    parameter int                    ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = BP_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  p_req,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_WIDTH-1:0] p_rdata,
    input  logic                  t_req,
    input  logic                  t_we,
    input  logic [ADDR_WIDTH-1:0] t_addr,
    input  logic [DATA_WIDTH-1:0] t_wdata,
    output logic                  t_gnt,
    output logic                  t_rvalid,
    output logic [DATA_WIDTH-1:0] t_rdata,
    output logic                  t_wdone,
    output logic                  addr_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(STORAGE_B);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(STORAGE_B - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic                    oor_q;
    logic                    fire;
    req_id_t                 pick;
    req_id_t                 last;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_oor;

    assign fire     = (state == ST_IDLE) && !clr_start && (p_req || t_req);
    assign sel_addr = (pick == REQ_T) ? t_addr : p_addr;
    assign sel_oor  = {1'b0, sel_addr} >= ADDR_LIMIT;

    // Gated by rst_n so an asserted reset kills the write strobe without waiting for a clock.
    assign mem_we = rst_n && ((state == ST_CLEAR_WE) || (state == ST_WRITE_WE && !oor_q));

    bp_rr_picker u_picker (
        .clk   (clk),
        .rst_n (rst_n),
        .p_req (p_req),
        .t_req (t_req),
        .fire  (fire),
        .pick  (pick),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR_WE;
            clr_ptr   <= '0;
            mem_addr  <= '0;
            mem_wdata <= CLR_VALUE;
            oor_q     <= 1'b0;
            clr_busy  <= 1'b1;
            clr_done  <= 1'b0;
            p_gnt     <= 1'b0;
            t_gnt     <= 1'b0;
            p_rvalid  <= 1'b0;
            t_rvalid  <= 1'b0;
            t_wdone   <= 1'b0;
            addr_err  <= 1'b0;
            p_rdata   <= '0;
            t_rdata   <= '0;
        end else begin
            clr_done <= 1'b0;
            p_gnt    <= 1'b0;
            t_gnt    <= 1'b0;
            p_rvalid <= 1'b0;
            t_rvalid <= 1'b0;
            t_wdone  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state     <= ST_CLEAR_WE;
                        clr_ptr   <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= CLR_VALUE;
                        clr_busy  <= 1'b1;
                    end else if (fire) begin
                        mem_addr <= sel_addr;
                        oor_q    <= sel_oor;
                        addr_err <= sel_oor;
                        if (pick == REQ_T) begin
                            t_gnt     <= 1'b1;
                            mem_wdata <= t_wdata;
                            state     <= t_we ? ST_WRITE_WE : ST_READ;
                        end else begin
                            p_gnt <= 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // The picker's last-granted flag names the owner of this read.
                    if (last == REQ_T) begin
                        t_rvalid <= 1'b1;
                        t_rdata  <= oor_q ? '0 : mem_rdata;
                    end else begin
                        p_rvalid <= 1'b1;
                        p_rdata  <= oor_q ? '0 : mem_rdata;
                    end
                    state <= ST_IDLE;
                end
                ST_WRITE_WE: begin
                    state <= ST_WRITE_HOLD;
                end
                ST_WRITE_HOLD: begin
                    t_wdone <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_CLEAR_WE: begin
                    state <= ST_CLEAR_HOLD;
                end
                ST_CLEAR_HOLD: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr  <= clr_ptr + 1'b1;
                        mem_addr <= clr_ptr + 1'b1;
                        state    <= ST_CLEAR_WE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
